mdio_master: RTL and testbench
==============================

# mdio_master

Serial management (MDIO, IEEE 802.3 clause 22) master that sits directly downstream of the PHY configuration block. It accepts single register write/read requests (PHY address, register address, data), serialises them into 64-bit management frames on MDC/MDIO, and reports completion through `busy` plus a read-data strobe. It is the only driver of the PHY management pins in the design.

## Interface
- `CLK_DIV`, 20: `clk` cycles per MDC half-period. Legal range is 2..255. A 50 MHz `clk` gives 1.25 MHz MDC.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `phy_add`  in  5  PHY address; captured on request.
- `reg_add`  in  5  register address; captured on request.
- `wr_data`  in  16  write data; captured on write request.
- `wren`  in  1  write request, single-cycle level sample.
- `rden`  in  1  read request, single-cycle level sample.
- `busy`  out  1  frame in progress; requests are ignored while high.
- `rd_data`  out  16  last read result; held until the next read completes.
- `rd_valid`  out  1  one-cycle pulse when `rd_data` has been updated.
- `rd_err`  out  1  valid with `rd_valid`. High when the PHY failed to drive the turnaround 0.
- `mdc`  out  1  management clock.
- `mdio_o`  out  1  MDIO output value.
- `mdio_oe`  out  1  MDIO output enable; the tristate buffer is external.
- `mdio_i`  in  1  MDIO input.

## Operation
- Reset values:
  - `busy`=0, `rd_data`=0, `rd_valid`=0, `rd_err`=0
  - `mdc`=0, `mdio_o`=1, `mdio_oe`=0
  - FSM is in IDLE and the divider is cleared.
- Requests:
  - Accepted only in IDLE with `busy`=0.
  - If `wren` and `rden` are high in the same cycle, the write wins and the read is dropped.
  - Requests arriving while `busy`=1 are discarded, not queued.
- FSM states: IDLE → PRE → CMD → TA → DATA → DONE → IDLE.
- Frame contents, MSB first, 64 bits:
  - PRE: 32 ones.
  - CMD: ST=01, then OP (write 01 / read 10), then PHYAD[4:0], then REGAD[4:0].
  - TA: write drives 10. Read releases the bus (`mdio_oe`=0) for both TA bits.
  - DATA: 16 bits. A write drives `wr_data`. A read samples `mdio_i` into a shift register.
- `mdio_oe` is 1 from the first PRE bit through the last DATA bit for writes, and through the last CMD bit for reads. It is 0 in IDLE and DONE.
- Read check: the second TA bit is sampled. If it reads 1, `rd_err`=1 for this transaction. The data bits are still shifted in and reported.
- DONE: lasts one `clk` cycle.
  - `busy` drops on the following cycle.
  - For reads, `rd_data`, `rd_err` and the `rd_valid` pulse are all presented in the DONE cycle.
- Reset mid-frame: the frame is aborted and every output returns to its reset value on the next `clk` edge. No partial `rd_valid` is produced.

## Timing
- Bit period = 2·`CLK_DIV` `clk` cycles. Each bit period is MDC low for `CLK_DIV` cycles, then high for `CLK_DIV` cycles.
- `mdio_o` and `mdio_oe` change only in the same cycle as the MDC falling edge. This gives a setup of ≥`CLK_DIV` cycles before the rising edge.
- `mdio_i` is sampled in the cycle where `mdc` goes 0→1 (rising-edge strobe).
- Sequence from a request sampled at cycle N:
  - `busy`=1 from N+1.
  - The first MDC half-period (low) starts at N+1.
  - DONE falls at N+1+128·`CLK_DIV`.
  - `busy`=0 at N+2+128·`CLK_DIV`.
- A new request may be sampled in the first cycle `busy` reads 0. Back-to-back frames are therefore separated by exactly 1 idle cycle.
- `mdc` stays 0 whenever the FSM is in IDLE.

## Structure
- Package `mdio_pkg` holds:
  - Constants: `MDIO_ST`=2'b01, `MDIO_OP_WR`=2'b01, `MDIO_OP_RD`=2'b10, `MDIO_TA_WR`=2'b10, `MDIO_PRE_LEN`=32, `MDIO_FRAME_LEN`=64.
  - The FSM state enum.
- Sub-module `mdc_gen` contains:
  - The divider counter, the `mdc` register, and single-cycle `rise`/`fall` strobes.
  - A `run` enable input; when `run`=0 it is held in reset with `mdc`=0.
- Top level contains:
  - The FSM, a 6-bit bit counter, a 32-bit TX shift register (CMD+TA+DATA), a 16-bit RX shift register, and the output registers.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `wren`=1 → `busy`=0, `mdc`=0, `mdio_oe`=0, `rd_data`=0 throughout; no MDC toggles.
- Write: `CLK_DIV`=2, `phy_add`=0, `reg_add`=0, `wr_data`=16'h3100 → the decoded frame is 32×1, 01 01 00000 00000 10 0011000100000000. `busy` is high for exactly 257 cycles. `mdio_oe`=1 for all 64 bits.
- Read: PHY model at address 1 returns 16'h796D for `reg_add`=2 → `rd_valid` pulses once with `rd_data`=16'h796D and `rd_err`=0. `mdio_oe`=0 from the first TA bit onward.
- No PHY: read with `mdio_i` held at 1 (pull-up) → `rd_valid` pulses with `rd_err`=1 and `rd_data`=16'hFFFF.
- Collisions:
  - `wren`+`rden` in the same cycle → only a write frame is produced.
  - A second `wren` pulsed mid-frame → ignored; exactly one frame is seen.
- Abort: assert `rst_n`=0 at bit 40 of a read → the next cycle shows all outputs at reset values and no `rd_valid`. A subsequent write completes normally.

Source files
------------

// File: rtl/mdio_pkg.sv
// mdio_pkg: shared constants and FSM state type for the clause-22 MDIO master.
// Bit positions are indices within the 64-bit management frame, MSB (first
// transmitted) = bit 0.
package mdio_pkg;

    localparam logic [1:0] MDIO_ST        = 2'b01;
    localparam logic [1:0] MDIO_OP_WR     = 2'b01;
    localparam logic [1:0] MDIO_OP_RD     = 2'b10;
    localparam logic [1:0] MDIO_TA_WR     = 2'b10;
    localparam int         MDIO_PRE_LEN   = 32;
    localparam int         MDIO_FRAME_LEN = 64;

    // ST(2) + OP(2) + PHYAD(5) + REGAD(5) follow the preamble.
    localparam int MDIO_TA_POS   = MDIO_PRE_LEN + 14;
    localparam int MDIO_DATA_POS = MDIO_TA_POS + 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_CMD,
        ST_TA,
        ST_DATA,
        ST_DONE
    } mdio_state_e;

endpackage

// File: rtl/mdio_master_mdc_gen.sv
// mdc_gen: MDC divider. Produces mdc with CLK_DIV clk cycles per half-period,
// starting low, plus single-cycle strobes asserted in the cycle before mdc
// toggles (rise_o: 0->1 on the next edge, fall_o: 1->0 on the next edge).
// Ports:
//   clk, rst_n   system clock, synchronous active-low reset
//   run_i        enable; when low the divider is cleared and mdc is 0
//   mdc_o        management clock
//   rise_o       mdc goes high at the next clk edge
//   fall_o       mdc goes low at the next clk edge
module mdc_gen #(
    parameter int CLK_DIV = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_i,
    output logic mdc_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int              CW      = $clog2(CLK_DIV);
    localparam logic [CW-1:0]   CNT_MAX = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic          mdc_q;
    logic          wrap;

    assign wrap = run_i && (cnt_q == CNT_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n || !run_i) begin
            cnt_q <= '0;
            mdc_q <= 1'b0;
        end else if (wrap) begin
            cnt_q <= '0;
            mdc_q <= ~mdc_q;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign mdc_o  = mdc_q;
    assign rise_o = wrap && !mdc_q;
    assign fall_o = wrap &&  mdc_q;

endmodule

// File: rtl/mdio_master.sv
// mdio_master: clause-22 MDIO master. Serialises one read or write request
// into a 64-bit frame (preamble, ST, OP, PHYAD, REGAD, TA, DATA).
// Ports:
//   clk, rst_n                system clock, synchronous active-low reset
//   phy_add, reg_add, wr_data request fields, captured on acceptance
//   wren, rden                request strobes (write wins if both)
//   busy                      frame in progress, requests ignored
//   rd_data, rd_err, rd_valid read result, error and one-cycle strobe
//   mdc, mdio_o, mdio_oe      management pins (external tristate)
//   mdio_i                    MDIO input
module mdio_master
    import mdio_pkg::*;
#(
    parameter int CLK_DIV = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  phy_add,
    input  logic [4:0]  reg_add,
    input  logic [15:0] wr_data,
    input  logic        wren,
    input  logic        rden,
    output logic        busy,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        rd_err,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i
);

    localparam logic [5:0] BIT_PRE_END = 6'(MDIO_PRE_LEN - 1);
    localparam logic [5:0] BIT_CMD     = 6'(MDIO_PRE_LEN);
    localparam logic [5:0] BIT_CMD_END = 6'(MDIO_TA_POS - 1);
    localparam logic [5:0] BIT_TA1     = 6'(MDIO_TA_POS);
    localparam logic [5:0] BIT_TA2     = 6'(MDIO_DATA_POS - 1);
    localparam logic [5:0] BIT_DATA    = 6'(MDIO_DATA_POS);
    localparam logic [5:0] BIT_LAST    = 6'(MDIO_FRAME_LEN - 1);

    mdio_state_e state_q, state_d;
    logic [5:0]  bit_q, bit_d, nxt_bit;
    logic [31:0] tx_q, tx_d;
    logic [15:0] rx_q, rx_d;
    logic        wr_q, wr_d;
    logic        err_q, err_d;
    logic        mdo_q, mdo_d;
    logic        oe_q, oe_d;
    logic [15:0] rd_data_q, rd_data_d;
    logic        rd_err_q, rd_err_d;
    logic        rd_valid_q, rd_valid_d;
    logic        run, rise, fall, start;

    assign start = (state_q == ST_IDLE) && (wren || rden);
    assign run   = (state_q != ST_IDLE) && (state_q != ST_DONE);

    mdc_gen #(.CLK_DIV(CLK_DIV)) u_mdc_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .run_i  (run),
        .mdc_o  (mdc),
        .rise_o (rise),
        .fall_o (fall)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state: phases advance on the MDC falling edge that ends their last bit
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start)                       state_d = ST_PRE;
            ST_PRE:  if (fall && bit_q == BIT_PRE_END) state_d = ST_CMD;
            ST_CMD:  if (fall && bit_q == BIT_CMD_END) state_d = ST_TA;
            ST_TA:   if (fall && bit_q == BIT_TA2)     state_d = ST_DATA;
            ST_DATA: if (fall && bit_q == BIT_LAST)    state_d = ST_DONE;
            ST_DONE:                                   state_d = ST_IDLE;
            default:                                   state_d = ST_IDLE;
        endcase
    end

    // Datapath / outputs. Pin values are registered and updated on the same
    // edge that drops mdc, so they are stable for the whole low+high period.
    always_comb begin
        bit_d      = bit_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        wr_d       = wr_q;
        err_d      = err_q;
        mdo_d      = mdo_q;
        oe_d       = oe_q;
        rd_data_d  = rd_data_q;
        rd_err_d   = rd_err_q;
        rd_valid_d = 1'b0;
        nxt_bit    = bit_q + 6'd1;

        if (start) begin
            bit_d = '0;
            wr_d  = wren;
            err_d = 1'b0;
            tx_d  = {MDIO_ST, wren ? MDIO_OP_WR : MDIO_OP_RD, phy_add, reg_add,
                     MDIO_TA_WR, wren ? wr_data : 16'h0000};
            mdo_d = 1'b1;
            oe_d  = 1'b1;
        end else if (fall) begin
            bit_d = nxt_bit;
            if (bit_q == BIT_LAST) begin
                // Entering DONE: release the bus and publish the read result.
                mdo_d = 1'b1;
                oe_d  = 1'b0;
                if (!wr_q) begin
                    rd_data_d  = rx_q;
                    rd_err_d   = err_q;
                    rd_valid_d = 1'b1;
                end
            end else begin
                oe_d  = wr_q || (nxt_bit < BIT_TA1);
                mdo_d = 1'b1;
                if (nxt_bit >= BIT_CMD) begin
                    tx_d = {tx_q[30:0], 1'b0};
                    if (oe_d) mdo_d = tx_q[31];
                end
            end
        end

        if (rise && !wr_q) begin
            // A PHY must pull the second TA bit low; a 1 means nobody answered.
            if (bit_q == BIT_TA2)  err_d = mdio_i;
            if (bit_q >= BIT_DATA) rx_d  = {rx_q[14:0], mdio_i};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_q      <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            wr_q       <= 1'b0;
            err_q      <= 1'b0;
            mdo_q      <= 1'b1;
            oe_q       <= 1'b0;
            rd_data_q  <= '0;
            rd_err_q   <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            bit_q      <= bit_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            wr_q       <= wr_d;
            err_q      <= err_d;
            mdo_q      <= mdo_d;
            oe_q       <= oe_d;
            rd_data_q  <= rd_data_d;
            rd_err_q   <= rd_err_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign rd_data  = rd_data_q;
    assign rd_err   = rd_err_q;
    assign rd_valid = rd_valid_q;
    assign mdio_o   = mdo_q;
    assign mdio_oe  = oe_q;

endmodule

// File: tb/tb_mdio_master.sv
// Bench for mdio_master: decodes frames on MDC rising edges, emulates a PHY
// at address 1 with a random register file, and compares against frames and
// read results built directly from the field layout of a clause-22 frame.
module tb_mdio_master;

    localparam int CLK_DIV   = 2;
    localparam int FRAME_CYC = 128 * CLK_DIV + 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  phy_add, reg_add;
    logic [15:0] wr_data;
    logic        wren, rden;
    logic        busy, rd_valid, rd_err, mdc, mdio_o, mdio_oe, mdio_i;
    logic [15:0] rd_data;

    mdio_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .phy_add(phy_add), .reg_add(reg_add),
        .wr_data(wr_data), .wren(wren), .rden(rden), .busy(busy),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err), .mdc(mdc),
        .mdio_o(mdio_o), .mdio_oe(mdio_oe), .mdio_i(mdio_i)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;

    // ---------------- monitors (monotonic counters only) ----------------
    logic [63:0] fr_bits = '0, fr_oe = '0;
    int          fr_n = 0;
    always @(posedge mdc) begin
        fr_bits = {fr_bits[62:0], mdio_o};
        fr_oe   = {fr_oe[62:0], mdio_oe};
        fr_n++;
    end

    int          busy_cnt = 0, rv_cnt = 0, rv_at = 0, idle_mdc = 0, chg_bad = 0;
    logic [15:0] rv_data = '0;
    logic        rv_err = 1'b0;
    logic        p_o = 1'b1, p_oe = 1'b0, p_mdc = 1'b0, p_busy = 1'b0;
    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (rd_valid) begin
            rv_cnt++;
            rv_at   = busy_cnt;
            rv_data = rd_data;
            rv_err  = rd_err;
        end
        if (!busy && mdc) idle_mdc++;
        // pins may only move together with an MDC fall (or at frame start)
        if (busy && p_busy && (mdio_o != p_o || mdio_oe != p_oe) && !(p_mdc && !mdc))
            chg_bad++;
        p_o = mdio_o; p_oe = mdio_oe; p_mdc = mdc; p_busy = busy;
    end

    // ---------------- PHY model ----------------
    logic [15:0] regs [32];
    int          phy_base = 0, phy_idx;
    logic        resp = 1'b0;
    logic [15:0] resp_val = '0;
    always @(negedge mdc) begin
        phy_idx = fr_n - phy_base;   // index of the bit that starts now
        if (phy_idx == 46) begin
            resp     = (fr_bits[13:10] == 4'b0110) && (fr_bits[9:5] == 5'd1);
            resp_val = regs[fr_bits[4:0]];
        end
        if (resp && phy_idx == 47)                      mdio_i = 1'b0;
        else if (resp && phy_idx >= 48 && phy_idx <= 63) mdio_i = resp_val[63 - phy_idx];
        else                                            mdio_i = 1'b1;
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic        w, r;
        logic [4:0]  pa, ra;
        logic [15:0] d;
        logic [63:0] exp_frame, exp_mask;
        logic [15:0] exp_rd;
        logic        exp_err;
    } vec_t;

    function automatic vec_t mkvec(logic w, logic r, logic [4:0] pa, logic [4:0] ra,
                                   logic [15:0] d);
        vec_t v;
        logic wr = w;   // write wins over read
        v.w = w; v.r = r; v.pa = pa; v.ra = ra; v.d = d;
        v.exp_frame = {32'hFFFF_FFFF, 2'b01, wr ? 2'b01 : 2'b10, pa, ra,
                       wr ? 2'b10 : 2'b00, wr ? d : 16'h0000};
        v.exp_mask  = wr ? {64{1'b1}} : {{46{1'b1}}, 18'h0};
        v.exp_rd    = (pa == 5'd1) ? regs[ra] : 16'hFFFF;
        v.exp_err   = (pa != 5'd1);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000 && busy; i++) @(negedge clk);
        if (busy) chk("idle_timeout", busy, 1'b0);
    endtask

    task automatic do_vec(input vec_t v, input int glitch_at);
        int b0, f0, r0;
        wait_idle();
        b0 = busy_cnt; f0 = fr_n; r0 = rv_cnt; phy_base = fr_n;
        wren = v.w; rden = v.r; phy_add = v.pa; reg_add = v.ra; wr_data = v.d;
        @(negedge clk);
        wren = 1'b0; rden = 1'b0;
        chk("busy_n1", busy, 1'b1);
        for (int i = 0; i < 2000 && busy; i++) begin
            if (i == glitch_at) begin
                wren = 1'b1; wr_data = ~v.d; phy_add = ~v.pa;
            end else begin
                wren = 1'b0;
            end
            @(negedge clk);
        end
        wren = 1'b0;
        if (busy) chk("frame_timeout", busy, 1'b0);
        chk("busy_cycles", busy_cnt - b0, FRAME_CYC);
        chk("mdc_rises", fr_n - f0, 64);
        chk("frame", fr_bits & v.exp_mask, v.exp_frame & v.exp_mask);
        chk("oe_mask", fr_oe, v.exp_mask);
        if (!v.w && v.r) begin
            chk("rv_count", rv_cnt - r0, 1);
            chk("rv_timing", rv_at - b0, FRAME_CYC);
            chk("rd_data", rv_data, v.exp_rd);
            chk("rd_err", rv_err, v.exp_err);
            chk("rd_data_held", rd_data, v.exp_rd);
        end else begin
            chk("rv_count", rv_cnt - r0, 0);
        end
    endtask

    vec_t vecs[10];

    initial begin
        int f0, r0, base;
        rst_n = 1'b0; wren = 1'b1; rden = 1'b0;
        phy_add = '0; reg_add = '0; wr_data = '0;
        for (int i = 0; i < 32; i++) regs[i] = 16'($urandom);
        regs[2] = 16'h796D;

        vecs[0] = mkvec(1'b1, 1'b0, 5'd0, 5'd0, 16'h3100);   // write
        vecs[1] = mkvec(1'b0, 1'b1, 5'd1, 5'd2, 16'h0000);   // PHY read
        vecs[2] = mkvec(1'b0, 1'b1, 5'd5, 5'd2, 16'h0000);   // no PHY
        vecs[3] = mkvec(1'b1, 1'b1, 5'd1, 5'd9, 16'hA5C3);   // write wins
        for (int i = 4; i < 10; i++)
            vecs[i] = mkvec(1'($urandom), 1'b1, 5'($urandom_range(0, 2)),
                            5'($urandom), 16'($urandom));

        // reset held with a pending write
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_busy", busy, 1'b0);
            chk("rst_mdc", mdc, 1'b0);
            chk("rst_oe", mdio_oe, 1'b0);
            chk("rst_rd_data", rd_data, 16'h0);
        end
        chk("rst_mdio_o", mdio_o, 1'b1);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_no_mdc", fr_n, 0);
        wren = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        chk("rst_after_busy", busy, 1'b0);

        for (int i = 0; i < 10; i++) do_vec(vecs[i], -1);

        // second wren mid-frame is dropped
        do_vec(vecs[0], 100);
        f0 = fr_n;
        repeat (40) @(negedge clk);
        chk("glitch_no_frame", fr_n - f0, 0);
        chk("glitch_idle", busy, 1'b0);

        // leave a known read result, then abort a read at bit 40
        do_vec(vecs[1], -1);
        wait_idle();
        base = fr_n; phy_base = fr_n; r0 = rv_cnt;
        rden = 1'b1; phy_add = 5'd1; reg_add = 5'd2;
        @(negedge clk);
        rden = 1'b0;
        for (int i = 0; i < 2000 && (fr_n - base) < 40; i++) @(negedge clk);
        chk("abort_reach", (fr_n - base) >= 40, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 1'b0);
        chk("abort_mdc", mdc, 1'b0);
        chk("abort_oe", mdio_oe, 1'b0);
        chk("abort_mdio_o", mdio_o, 1'b1);
        chk("abort_rd_valid", rd_valid, 1'b0);
        chk("abort_rd_data", rd_data, 16'h0);
        chk("abort_rd_err", rd_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_no_rv", rv_cnt - r0, 0);
        do_vec(vecs[0], -1);

        chk("idle_mdc", idle_mdc, 0);
        chk("pin_change", chg_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
